mat_mult_loader: RTL
====================

Name: mat_mult_loader

Overview:
- Upstream feeder for the 3x3 multiplier. Accepts matrix elements one at a time on a 16-bit valid/ready stream and packs them into the two 144-bit matrix streams.
- Sequences the multiplier's mult_en so that each loaded pair is multiplied exactly once, then signals completion.
- Sits between the element source (host FIFO / test harness) and the multiplier; its outputs drive the multiplier's matrix_a_stream, matrix_b_stream and mult_en directly.

Parameters:
- ELEM_W, 16, element width; must equal the multiplier's element width.
- SETTLE_CYCLES, 1, cycles between the final stream update and mult_en assertion; legal range 1..7. The multiplier registers its inputs one cycle before multiplying, so it needs at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  ELEM_W  element value
- in_valid  in  1  source has an element
- in_ready  out  1  loader accepts an element this cycle
- matrix_a_stream  out  9*ELEM_W  packed A, a1 at [143:128] down to a9 at [15:0]
- matrix_b_stream  out  9*ELEM_W  packed B, same order
- mult_en  out  1  multiply enable to the multiplier, registered
- done  out  1  one-cycle pulse; multiplier result valid this cycle
- busy  out  1  high in any state other than LOAD

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high; no other reset.
- Reset values: state=LOAD, elem_cnt=0, both streams=0, mult_en=0, done=0, settle counter=0. in_ready is forced 0 while rst is high.
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready. in_ready = (state==LOAD) && !rst, decoded from registered state with no combinational path from in_valid. in_data is sampled only on a transfer.
- Packing: transfer number k (0..17) is written into the streams.
  - k=0..8 goes to matrix_a_stream[143-16k -: 16].
  - k=9..17 goes to matrix_b_stream[143-16(k-9) -: 16].
  - Both elements are in row-major order (e1,e2,e3 = row 1).
  - Untouched slots hold their previous value.
- States:
  - LOAD: in_ready=1; elem_cnt increments per transfer. The transfer with elem_cnt=17 moves to SETTLE and clears elem_cnt.
  - SETTLE: in_ready=0; counts SETTLE_CYCLES cycles, then moves to FIRE.
  - FIRE: mult_en=1 for exactly one cycle, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then returns to LOAD.
- Latency: the final transfer occurs on edge E.
  - mult_en is high in the cycle following edge E+SETTLE_CYCLES.
  - done is high in the cycle following edge E+SETTLE_CYCLES+1.
  - With the default parameter, done is high 3 cycles after the final-transfer cycle.
  - While done is high, matrix_c_stream on the multiplier holds the product.
- Stream stability: both streams are frozen from the final transfer until the next transfer in LOAD. The multiplier result therefore stays valid after done until new elements arrive.
- Back-to-back: the first transfer of the next load may occur in the cycle after DONE. Minimum period is 18 + SETTLE_CYCLES + 2 cycles.
- in_valid outside LOAD: ignored; no transfer, and the source must hold its element.
- Reset mid-operation: from any state, rst returns to LOAD with elem_cnt=0 and zeroed streams. A partial load is discarded. mult_en and done drop on the reset edge.
- Arithmetic: elem_cnt is 5 bits and saturates logically at 17, because the wrap is handled by the state transition. The settle counter is 3 bits.

Optional Feature:
- Macro: MAT_LOADER_B_REUSE_EN (weight-stationary mode).
- When defined:
  - Adds input port b_reload (1 bit).
  - After the first complete 18-element load, later loads accept only 9 elements (A). The transfer with elem_cnt=8 moves to SETTLE and matrix_b_stream is retained.
  - Sampling b_reload=1 in DONE, or rst, forces the next load to take all 18 elements.
- When undefined: no b_reload port; every load is 18 elements.

Test Plan:
- Load A=identity (1,0,0,0,1,0,0,0,1) and B=1..9 with in_valid held high. Required: in_ready drops after the 18th transfer; mult_en is a single pulse 2 cycles later; done is a single pulse 3 cycles after the last transfer; matrix_c_stream = {1,2,...,9}.
- Load A=1..9 and B=9..1 with random in_valid gaps of 0-3 cycles. Required: packed streams equal 0x0001_0002_..._0009 and 0x0009_..._0001; product row 1 = 30,24,18.
- Assert in_valid continuously during SETTLE, FIRE and DONE with data 0xFFFF. Required: no transfer occurs and the streams are unchanged.
- Assert rst after 10 transfers. Required: both streams read 0, in_ready is 0 in the reset cycle and 1 after it; the next full load gives a correct product and no stray mult_en.
- Run two back-to-back loads. Required: the second load's first transfer is accepted in the cycle after done; exactly two mult_en pulses and two done pulses.
- With MAT_LOADER_B_REUSE_EN: load B=identity once, then A=2..10 (9 elements only). Required: done follows the 9th transfer and the product equals A; with b_reload=1 in DONE, the next load requires 18 elements.

Source files
------------

// File: rtl/mat_mult_loader.sv
// mat_mult_loader: packs a 16-bit element stream into the 3x3 multiplier's A/B streams and sequences mult_en/done.
// Latency: mult_en in the cycle after edge E+SETTLE_CYCLES (E = final transfer), done one cycle later.
// Backpressure: in_ready is high only in LOAD (decoded from registered state), so the source holds its element while busy.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready element stream;
//        matrix_a_stream/matrix_b_stream packed a1..a9 / b1..b9 (e1 at the MSBs);
//        mult_en (registered), done (1-cycle pulse), busy (state != LOAD).
// Optional: MAT_LOADER_B_REUSE_EN adds b_reload; after one full load, later loads carry only A.
module mat_mult_loader #(
   parameter int ELEM_W        = 16,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef MAT_LOADER_B_REUSE_EN
   input  logic                  b_reload,
`endif
   input  logic [ELEM_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [9*ELEM_W-1:0]   matrix_a_stream,
   output logic [9*ELEM_W-1:0]   matrix_b_stream,
   output logic                  mult_en,
   output logic                  done,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_FIRE   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

   state_t               state_q, state_d;
   logic [4:0]           elem_cnt_q, elem_cnt_d;
   logic [2:0]           settle_q, settle_d;
   logic [9*ELEM_W-1:0]  a_q, a_d, b_q, b_d;
   logic                 mult_en_q, mult_en_d;
   logic                 done_q, done_d;
   logic                 xfer;
   logic [3:0]           slot;
   logic [4:0]           last_cnt;

`ifdef MAT_LOADER_B_REUSE_EN
   // Set once a complete A+B load has been taken; B is then reused.
   logic                 b_loaded_q, b_loaded_d;
   assign last_cnt = b_loaded_q ? 5'd8 : 5'd17;
`else
   assign last_cnt = 5'd17;
`endif

   assign in_ready = (state_q == ST_LOAD) && !rst;
   assign xfer     = in_valid && in_ready;
   // Slot within the current matrix: 0..8 for A, 9..17 fold back onto 0..8 for B.
   assign slot     = (elem_cnt_q < 5'd9) ? elem_cnt_q[3:0] : 4'(elem_cnt_q - 5'd9);

   always_comb begin
      state_d    = state_q;
      elem_cnt_d = elem_cnt_q;
      settle_d   = settle_q;
      a_d        = a_q;
      b_d        = b_q;
`ifdef MAT_LOADER_B_REUSE_EN
      b_loaded_d = b_loaded_q;
`endif
      case (state_q)
         ST_LOAD: begin
            if (xfer) begin
               if (elem_cnt_q < 5'd9) begin
                  a_d[(8 - int'(slot))*ELEM_W +: ELEM_W] = in_data;
               end else begin
                  b_d[(8 - int'(slot))*ELEM_W +: ELEM_W] = in_data;
               end
               if (elem_cnt_q == last_cnt) begin
                  state_d    = ST_SETTLE;
                  elem_cnt_d = 5'd0;
`ifdef MAT_LOADER_B_REUSE_EN
                  b_loaded_d = 1'b1;
`endif
               end else begin
                  elem_cnt_d = elem_cnt_q + 5'd1;
               end
            end
         end
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d  = ST_FIRE;
               settle_d = 3'd0;
            end else begin
               settle_d = settle_q + 3'd1;
            end
         end
         ST_FIRE: begin
            state_d = ST_DONE;
         end
         default: begin
`ifdef MAT_LOADER_B_REUSE_EN
            if (b_reload) begin
               b_loaded_d = 1'b0;
            end
`endif
            state_d = ST_LOAD;
         end
      endcase
      // Outputs are registered, so they follow the state being entered.
      mult_en_d = (state_d == ST_FIRE);
      done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         elem_cnt_q <= 5'd0;
         settle_q   <= 3'd0;
         a_q        <= '0;
         b_q        <= '0;
         mult_en_q  <= 1'b0;
         done_q     <= 1'b0;
`ifdef MAT_LOADER_B_REUSE_EN
         b_loaded_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         elem_cnt_q <= elem_cnt_d;
         settle_q   <= settle_d;
         a_q        <= a_d;
         b_q        <= b_d;
         mult_en_q  <= mult_en_d;
         done_q     <= done_d;
`ifdef MAT_LOADER_B_REUSE_EN
         b_loaded_q <= b_loaded_d;
`endif
      end
   end

   assign matrix_a_stream = a_q;
   assign matrix_b_stream = b_q;
   assign mult_en         = mult_en_q;
   assign done            = done_q;
   assign busy            = (state_q != ST_LOAD);

endmodule
